gpmc16_to_fifo36: RTL

//  Host-to-FPGA write path for the GPMC/GPIF bus. Packs 16-bit bus transfers (with end-of-frame

---
 rtl/gpmc16_to_fifo36.sv | 113 +++++++++++
 1 files changed

// File: rtl/gpmc16_to_fifo36.sv
// Packs 16-bit GPMC writes into fifo36 words into an internal FWFT buffer; push lands on out_data one cycle after the transfer.
// No backpressure to the bus: words arriving while full are dropped and flagged; has_space is the host's flow-control hint.
module gpmc16_to_fifo36 #(
    parameter int FIFO_SIZE   = 9,
    parameter int MIN_SPACE16 = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_eof,
    output logic        has_space,
    output logic        overflow,
    output logic [35:0] out_data,
    output logic        out_src_rdy,
    input  logic        out_dst_rdy
);
    localparam int DEPTH = 2 ** FIFO_SIZE;
    localparam int CW    = FIFO_SIZE + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   MIN_C   = (CW + 1)'(MIN_SPACE16);

    typedef enum logic {LOW, HIGH} state_t;

    state_t                state;
    logic [15:0]           low_half;
    logic                  sof_pend;
    logic [FIFO_SIZE-1:0]  wr_ptr;
    logic [FIFO_SIZE-1:0]  rd_ptr;
    logic [CW-1:0]         occ;
    logic [35:0]           mem [DEPTH];

    logic                  push;
    logic [35:0]           push_word;
    logic                  full;
    logic                  wr_en;
    logic                  pop;
    logic [CW:0]           free2;

    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (in_valid && !clear) begin
            if (state == HIGH) begin
                push      = 1'b1;
                push_word = {2'b00, in_eof, sof_pend, in_data, low_half};
            end else if (in_eof) begin
                push      = 1'b1;
                push_word = {2'b10, 1'b1, sof_pend, 16'h0000, in_data};
            end
        end
    end

    assign full        = (occ == DEPTH_C);
    assign wr_en       = push && !full;
    assign out_src_rdy = (occ != '0);
    assign pop         = out_src_rdy && out_dst_rdy && !clear;
    assign free2       = {DEPTH_C - occ, 1'b0};
    assign out_data    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= LOW;
            low_half  <= '0;
            sof_pend  <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            has_space <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear) begin
            state     <= LOW;
            low_half  <= '0;
            sof_pend  <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            has_space <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (in_valid) begin
                if (state == LOW && !in_eof) begin
                    low_half <= in_data;
                    state    <= HIGH;
                end else begin
                    state    <= LOW;
                end
            end
            // Dropped words still advance framing so SOF realigns after overflow
            if (push) begin
                sof_pend <= in_eof;
                if (full)
                    overflow <= 1'b1;
            end
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            has_space <= (free2 >= MIN_C);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= push_word;
    end
endmodule
